// File: rtl/tank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tank_pkg                                                       |
// | Purpose  : Shared types and constants for the tank controller: fire-state |
// |            enum, default key codes and terrain curve coefficients.       |
// | Config   : TANK_AMMO_EN adds the EMPTY fire state.                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package tank_pkg;

  // The encoding is two bits in both builds, so the state register width
  // does not depend on the configuration.
  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_FIRE     = 2'd1,
    ST_COOLDOWN = 2'd2
`ifdef TANK_AMMO_EN
    , ST_EMPTY  = 2'd3
`endif
  } fire_state_t;

  // Default key codes (keyboard usage IDs)
  localparam logic [7:0] c_key_left     = 8'h04;
  localparam logic [7:0] c_key_right    = 8'h07;
  localparam logic [7:0] c_key_aim_inc  = 8'h16;
  localparam logic [7:0] c_key_aim_dec  = 8'h1A;
  localparam logic [7:0] c_key_fire     = 8'h2C;
  localparam logic [7:0] c_key_reload   = 8'h19;

  // Terrain: Y = A_NUM*X^2/A_DEN - B_NUM*X/B_DEN + C
  localparam int unsigned c_ty_a_num = 32'd607;
  localparam int unsigned c_ty_a_den = 32'd1562500;
  localparam int unsigned c_ty_b_num = 32'd71;
  localparam int unsigned c_ty_b_den = 32'd500;
  localparam int unsigned c_ty_c     = 32'd222;

endpackage
`default_nettype wire

// File: rtl/tank_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tank_ctrl_if                                                   |
// | Purpose  : Shot request handshake between the tank controller (master)   |
// |            and the projectile unit (slave).                              |
// | Signals  : shoot_valid  master->slave  shot request                       |
// |            shoot_ready  slave->master  shot accepted                      |
// |            shoot_x/y    master->slave  shot origin (10 bit)               |
// |            shoot_aim    master->slave  signed aim (10 bit)                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface tank_ctrl_if;
  logic       shoot_valid;
  logic       shoot_ready;
  logic [9:0] shoot_x;
  logic [9:0] shoot_y;
  logic [9:0] shoot_aim;

  modport master (
    output shoot_valid, shoot_x, shoot_y, shoot_aim,
    input  shoot_ready
  );

  modport slave (
    input  shoot_valid, shoot_x, shoot_y, shoot_aim,
    output shoot_ready
  );
endinterface
`default_nettype wire

// File: rtl/terrain_y.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : terrain_y                                                      |
// | Purpose  : Combinational terrain height lookup,                           |
// |            Y = 607*X^2/1562500 - 71*X/500 + 222.                          |
// | Ports    : x  in  10  horizontal position                                 |
// |            y  out 10  terrain height at x                                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module terrain_y
  import tank_pkg::*;
(
  input  logic [9:0] x,
  output logic [9:0] y
);

  logic [31:0] w_x32;
  logic [31:0] w_sq;
  logic [31:0] w_lin;

  assign w_x32 = {22'd0, x};
  assign w_sq  = w_x32 * w_x32;
  assign w_lin = (w_x32 * c_ty_b_num) / c_ty_b_den;

  // Each term is divided separately. The constant is added before the
  // linear term is subtracted so the 32-bit sum never goes negative.
  assign y = 10'(((w_sq * c_ty_a_num) / c_ty_a_den) + c_ty_c - w_lin);

endmodule
`default_nettype wire

// File: rtl/tank_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tank_ctrl                                                      |
// | Purpose  : Player tank: keyboard-driven movement, aiming and a shot       |
// |            request FSM (READY/FIRE/COOLDOWN[/EMPTY]) with valid/ready     |
// |            handshake toward the projectile unit.                          |
// | Config   : TANK_AMMO_EN - enables magazine tracking, RELOAD and EMPTY.    |
// |            Without it ammo reads constant AMMO_MAX.                       |
// | Ports    : frame_clk  in   1   one rising edge per frame                  |
// |            Reset_n    in   1   asynchronous active-low reset              |
// |            keycode    in   8   current key, 0 = none                      |
// |            TankX      out 10   tank X position                            |
// |            TankY      out 10   terrain Y at TankX                         |
// |            Direction  out  2   0 = left, 1 = right                        |
// |            aim        out 10   signed aim offset                          |
// |            ammo       out  4   rounds remaining                           |
// |            shot       if       master side of the shot handshake          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tank_ctrl
  import tank_pkg::*;
#(
  parameter int         X_INIT     = 140,
  parameter int         X_MIN      = 4,
  parameter int         X_MAX      = 635,
  parameter int         X_STEP     = 1,
  parameter int         AIM_STEP   = 3,
  parameter int         AIM_MAX    = 60,
  parameter int         COOLDOWN   = 30,
  parameter int         AMMO_MAX   = 5,
  parameter logic [7:0] KEY_LEFT    = c_key_left,
  parameter logic [7:0] KEY_RIGHT   = c_key_right,
  parameter logic [7:0] KEY_AIM_INC = c_key_aim_inc,
  parameter logic [7:0] KEY_AIM_DEC = c_key_aim_dec,
  parameter logic [7:0] KEY_FIRE    = c_key_fire,
  parameter logic [7:0] KEY_RELOAD  = c_key_reload
)(
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  output logic [9:0]  TankX,
  output logic [9:0]  TankY,
  output logic [1:0]  Direction,
  output logic [9:0]  aim,
  output logic [3:0]  ammo,
  tank_ctrl_if.master shot
);

  // Counter only needs to hold COOLDOWN-1
  localparam int c_cnt_w = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  logic [9:0]         r_x;
  logic [1:0]         r_dir;
  logic [9:0]         r_aim;
  logic [7:0]         r_prev_key;
  fire_state_t        r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_shoot_valid;
  logic [9:0]         r_sx;
  logic [9:0]         r_sy;
  logic [9:0]         r_saim;
`ifdef TANK_AMMO_EN
  logic [3:0]         r_ammo;
`endif

  logic [9:0]         w_y;
  logic               w_key_edge;
  logic               w_fire_edge;
  logic               w_has_ammo;
  logic [10:0]        w_x_ext;
  logic [9:0]         w_x_left;
  logic [9:0]         w_x_right;
  logic signed [10:0] w_aim_ext;
  logic signed [10:0] w_aim_up;
  logic signed [10:0] w_aim_dn;
  logic signed [10:0] w_aim_lim;
  logic [9:0]         w_aim_inc;
  logic [9:0]         w_aim_dec;

  terrain_y u_terrain (
    .x (r_x),
    .y (w_y)
  );

  // Discrete actions fire once per press: only when the key just changed.
  assign w_key_edge  = (keycode != r_prev_key);
  assign w_fire_edge = w_key_edge && (keycode == KEY_FIRE);

  // Clamp in 11 bits so X_MAX + X_STEP cannot wrap around.
  assign w_x_ext   = {1'b0, r_x};
  assign w_x_left  = (w_x_ext >= 11'(X_MIN + X_STEP)) ? (r_x - 10'(X_STEP)) : 10'(X_MIN);
  assign w_x_right = ((w_x_ext + 11'(X_STEP)) <= 11'(X_MAX)) ? (r_x + 10'(X_STEP)) : 10'(X_MAX);

  // Aim saturation done in signed 11 bits to avoid overflow at the limits.
  assign w_aim_ext = {r_aim[9], r_aim};
  assign w_aim_lim = 11'(AIM_MAX);
  assign w_aim_up  = w_aim_ext + 11'(AIM_STEP);
  assign w_aim_dn  = w_aim_ext - 11'(AIM_STEP);
  assign w_aim_inc = (w_aim_up > w_aim_lim)  ? 10'(w_aim_lim)  : 10'(w_aim_up);
  assign w_aim_dec = (w_aim_dn < -w_aim_lim) ? 10'(-w_aim_lim) : 10'(w_aim_dn);

  // Movement and aiming; frozen while a shot request is outstanding.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x        <= 10'(X_INIT);
      r_dir      <= 2'd1;
      r_aim      <= '0;
      r_prev_key <= '0;
    end else begin
      r_prev_key <= keycode;
      if (!r_shoot_valid) begin
        if (keycode == KEY_LEFT) begin
          r_x   <= w_x_left;
          r_dir <= 2'd0;
        end else if (keycode == KEY_RIGHT) begin
          r_x   <= w_x_right;
          r_dir <= 2'd1;
        end else if (w_key_edge && (keycode == KEY_AIM_INC)) begin
          r_aim <= w_aim_inc;
        end else if (w_key_edge && (keycode == KEY_AIM_DEC)) begin
          r_aim <= w_aim_dec;
        end
      end
    end
  end

`ifdef TANK_AMMO_EN
  logic w_reload_edge;
  assign w_reload_edge = w_key_edge && (keycode == KEY_RELOAD);
  assign w_has_ammo    = (r_ammo != 4'd0);
  assign ammo          = r_ammo;
`else
  assign w_has_ammo    = 1'b1;
  assign ammo          = 4'(AMMO_MAX);
`endif

  // Fire FSM. Payload is latched on the FIRE edge and held until the
  // handshake; FIRE edges outside READY are dropped, never queued.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= ST_READY;
      r_shoot_valid <= 1'b0;
      r_sx          <= '0;
      r_sy          <= '0;
      r_saim        <= '0;
      r_cnt         <= '0;
`ifdef TANK_AMMO_EN
      r_ammo        <= 4'(AMMO_MAX);
`endif
    end else begin
      case (r_state)
        ST_READY: begin
          if (w_fire_edge && w_has_ammo) begin
            r_state       <= ST_FIRE;
            r_shoot_valid <= 1'b1;
            r_sx          <= r_x;
            r_sy          <= w_y;
            r_saim        <= r_aim;
          end
`ifdef TANK_AMMO_EN
          else if (w_reload_edge) begin
            r_ammo <= 4'(AMMO_MAX);
          end
`endif
        end
        ST_FIRE: begin
          if (shot.shoot_ready) begin
            r_shoot_valid <= 1'b0;
            r_cnt         <= c_cnt_w'(COOLDOWN - 1);
            r_state       <= ST_COOLDOWN;
`ifdef TANK_AMMO_EN
            r_ammo        <= r_ammo - 4'd1;
`endif
          end
        end
        ST_COOLDOWN: begin
          if (r_cnt == '0) begin
`ifdef TANK_AMMO_EN
            r_state <= w_has_ammo ? ST_READY : ST_EMPTY;
`else
            r_state <= ST_READY;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef TANK_AMMO_EN
        ST_EMPTY: begin
          if (w_reload_edge) begin
            r_ammo  <= 4'(AMMO_MAX);
            r_state <= ST_READY;
          end
        end
`endif
        default: begin
          r_state       <= ST_READY;
          r_shoot_valid <= 1'b0;
        end
      endcase
    end
  end

  assign TankX            = r_x;
  assign TankY            = w_y;
  assign Direction        = r_dir;
  assign aim              = r_aim;
  assign shot.shoot_valid = r_shoot_valid;
  assign shot.shoot_x     = r_sx;
  assign shot.shoot_y     = r_sy;
  assign shot.shoot_aim   = r_saim;

endmodule
`default_nettype wire

// File: doc/tank_ctrl.md
TANK_CTRL -- requirements
Module: tank_ctrl

Interface
REQ-001 SHALL have parameters: X_INIT=140 (reset X); X_MIN=4, X_MAX=635 (X clamp limits); X_STEP=1 (pixels/frame); AIM_STEP=3 (aim change per press); AIM_MAX=60 (aim magnitude limit); COOLDOWN=30 (frames between shots, >=1); AMMO_MAX=5 (magazine size, 1..15).
REQ-002 SHALL have key parameters: KEY_LEFT=8'h04, KEY_RIGHT=8'h07, KEY_AIM_INC=8'h16, KEY_AIM_DEC=8'h1A, KEY_FIRE=8'h2C, KEY_RELOAD=8'h19.
REQ-003 SHALL have these ports:
  frame_clk  in  1  one clock, one edge per frame
  Reset_n  in  1  asynchronous, active-low reset
  keycode  in  8  current key, 0 = none
  TankX  out  10  tank X position
  TankY  out  10  terrain Y at TankX
  Direction  out  2  facing: 0 = left, 1 = right
  aim  out  10  signed aim offset (two's complement)
  shoot_valid  out  1  shot request
  shoot_ready  in  1  projectile unit accepts shot
  shoot_x, shoot_y  out  10  shot origin
  shoot_aim  out  10  shot aim
  ammo  out  4  rounds remaining

Function
REQ-004 SHALL, on LEFT, set TankX <= max(X_MIN, TankX-X_STEP) and Direction <= 0; RIGHT mirrors this with min(X_MAX, TankX+X_STEP) and Direction <= 1; no bounce.
REQ-005 SHALL hold TankX, Direction and aim unchanged while shoot_valid=1.
REQ-006 SHALL drive TankY combinationally as 607*X^2/1562500 - 71*X/500 + 222 with X = TankX; use 32-bit unsigned intermediates, integer-divide each term, truncate to 10 bits (X=140 -> 210).
REQ-007 SHALL act on AIM_INC, AIM_DEC, FIRE and RELOAD only on a press edge, i.e. keycode differs from the previous frame's keycode; held keys act once.
REQ-008 SHALL add AIM_STEP on an AIM_INC edge, saturating at +AIM_MAX; SHALL subtract AIM_STEP on an AIM_DEC edge, saturating at -AIM_MAX.
REQ-009 SHALL implement fire FSM states READY, FIRE, COOLDOWN and EMPTY.
REQ-010 SHALL go READY -> FIRE on a FIRE edge with ammo>0; the same edge latches shoot_x=TankX, shoot_y=TankY and shoot_aim=aim.
REQ-011 SHALL assert shoot_valid in FIRE only; payload SHALL stay stable until the frame in which shoot_valid && shoot_ready.
REQ-012 SHALL, on that handshake, decrement ammo, load the cooldown counter with COOLDOWN-1 and enter COOLDOWN.
REQ-013 SHALL leave COOLDOWN when the counter is 0: to READY if ammo>0, else to EMPTY; a FIRE edge during COOLDOWN or EMPTY is discarded, not queued.
REQ-014 SHALL, on a RELOAD edge in READY or EMPTY, set ammo=AMMO_MAX and state=READY; RELOAD SHALL be ignored in FIRE and COOLDOWN.
REQ-015 SHALL accept shoot_ready when shoot_valid=0 with no effect.

Reset
REQ-016 SHALL, on Reset_n low and regardless of state (including mid-FIRE), set: TankX=X_INIT, Direction=1, aim=0, state=READY, ammo=AMMO_MAX, shoot_valid=0, shoot_x/y/aim=0, counter=0, previous keycode=0.

Configuration
REQ-017 SHALL compile in ammo tracking and the EMPTY state only when TANK_AMMO_EN is defined.
REQ-018 SHALL, without TANK_AMMO_EN: keep ammo constant at AMMO_MAX, exit COOLDOWN always to READY, and ignore RELOAD.

Structure
REQ-019 SHALL place the fire-state enum, key defaults and terrain coefficients in package tank_pkg.
REQ-020 SHALL implement the terrain equation in sub-module terrain_y (10-bit X in, 10-bit Y out, purely combinational).

Verification
REQ-021 SHALL cover reset: TankX=140, TankY=210, ammo=5, shoot_valid=0.
REQ-022 SHALL cover clamping: LEFT held 200 frames from reset -> TankX=4, Direction=0, no wrap.
REQ-023 SHALL cover aim: 25 separate AIM_INC presses -> aim=60; AIM_INC held 10 frames -> aim +3 only.
REQ-024 SHALL cover handshake: FIRE edge with shoot_ready=0 for 5 frames -> shoot_valid stays 1, payload stable, TankX frozen; then shoot_ready=1 -> ammo=4 and 30 frames later state=READY.
REQ-025 SHALL cover ammo (TANK_AMMO_EN): 5 shots -> EMPTY, a 6th FIRE edge gives no shoot_valid, RELOAD -> ammo=5 and READY.
REQ-026 SHALL cover reset mid-shot: Reset_n low while shoot_valid=1 -> shoot_valid=0 immediately (asynchronously) and ammo=5.
